// File: rtl/barret_arb_1213.sv
// ---------------------------------------------------------------------------
// barret_arb_1213
//
// Two-requester round-robin arbiter in front of a shared 3-stage Barrett
// reduction pipeline computing a mod Q for 21-bit operands.
//
//   S1  operand capture       (valid, operand, requester id)
//   S2  quotient estimate     (valid, partial remainder r, id)
//   S3  output register       (valid, reduced result, id) -> out_*
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req0_valid/data/ready     requester 0 operand handshake
//   req1_valid/data/ready     requester 1 operand handshake
//   out_valid/data/id/ready   reduced result handshake (id = issuing requester)
//   busy                      any pipeline stage holds a valid entry
//   done_cnt                  number of results transferred, wraps at 16 bits
//
// The whole pipeline stalls as a unit whenever S3 holds a result that the
// consumer does not take, so results always leave in acceptance order.
// ---------------------------------------------------------------------------
module barret_arb_1213 #(
    parameter int Q  = 1213,
    parameter int MU = 3457,
    parameter int K  = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [20:0]  req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [20:0]  req1_data,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [K-1:0] out_data,
    output logic         out_id,
    input  logic         out_ready,
    output logic         busy,
    output logic [15:0]  done_cnt
);

    localparam int W = 21;
    localparam logic [W-1:0] Q_W  = W'(Q);
    localparam logic [W-1:0] MU_W = W'(MU);

    // Requester vectors so the per-requester handshake can be generated.
    logic [1:0]   req_valid;
    logic [W-1:0] req_data [2];
    logic [1:0]   req_ready;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Pipeline state
    logic         ptr_reg;
    logic         s1_valid_reg;
    logic [W-1:0] s1_data_reg;
    logic         s1_id_reg;
    logic         s2_valid_reg;
    logic [W-1:0] s2_r_reg;
    logic         s2_id_reg;
    logic         s3_valid_reg;
    logic [K-1:0] s3_data_reg;
    logic         s3_id_reg;
    logic [15:0]  done_cnt_reg;

    logic         stall;
    logic         grant;
    logic         accept;
    logic [W-1:0] accept_data;

    // A result sitting in S3 that is not being taken freezes every stage.
    assign stall = s3_valid_reg && !out_ready;

    // Round-robin: the pointer only matters when both requesters compete.
    always_comb begin
        grant = ptr_reg;
        if (req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            // Ready is suppressed during reset so nothing is accepted into a
            // pipeline that is being cleared on the same edge.
            assign req_ready[gi] = !stall && !rst && req_valid[gi] && (grant == 1'(gi));
        end
    endgenerate

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign accept      = |req_ready;
    assign accept_data = req_data[grant];

    // S2 quotient estimate. Every intermediate is kept to 21 bits so the
    // arithmetic wraps exactly like the reference model, including for
    // operands near 2^21 where qv*MU overflows.
    logic [W-1:0] qv_next;
    logic [W-1:0] qh_next;
    logic [W-1:0] t_next;
    logic [W-1:0] m_next;
    logic [W-1:0] r_next;

    always_comb begin
        qv_next = s1_data_reg >> K;
        qh_next = qv_next * MU_W;
        t_next  = qh_next >> K;
        m_next  = t_next * Q_W;
        r_next  = s1_data_reg - m_next;
    end

    // S3 final conditional subtraction, then truncation to the result width.
    logic [K-1:0] out_data_next;

    always_comb begin
        out_data_next = K'((s2_r_reg >= Q_W) ? (s2_r_reg - Q_W) : s2_r_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_id_reg    <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_r_reg     <= '0;
            s2_id_reg    <= 1'b0;
            s3_valid_reg <= 1'b0;
            s3_data_reg  <= '0;
            s3_id_reg    <= 1'b0;
            done_cnt_reg <= '0;
        end else begin
            if (accept) begin
                ptr_reg <= ~grant;
            end

            if (!stall) begin
                // S1: capture the granted operand, or a bubble.
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_data_reg <= accept_data;
                    s1_id_reg   <= grant;
                end

                // S2: partial remainder.
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_r_reg  <= r_next;
                    s2_id_reg <= s1_id_reg;
                end

                // S3: data/id only move with a valid entry so a bubble leaves
                // the last result visible rather than garbage.
                s3_valid_reg <= s2_valid_reg;
                if (s2_valid_reg) begin
                    s3_data_reg <= out_data_next;
                    s3_id_reg   <= s2_id_reg;
                end
            end

            if (s3_valid_reg && out_ready) begin
                done_cnt_reg <= done_cnt_reg + 16'd1;
            end
        end
    end

    assign out_valid = s3_valid_reg;
    assign out_data  = s3_data_reg;
    assign out_id    = s3_id_reg;
    assign done_cnt  = done_cnt_reg;
    assign busy      = s1_valid_reg | s2_valid_reg | s3_valid_reg;

endmodule

// File: tb/tb_barret_arb_1213.sv
// ---------------------------------------------------------------------------
// tb_barret_arb_1213
//
// Directed bench for barret_arb_1213. Inputs change 1 ns after a rising edge
// and outputs are sampled 1 ns later, well away from the next rising edge.
// Expected results are hand-computed Barrett reductions mod 1213.
// ---------------------------------------------------------------------------
module tb_barret_arb_1213;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [20:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [20:0] req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic [10:0] out_data;
    logic        out_id;
    logic        out_ready;
    logic        busy;
    logic [15:0] done_cnt;

    int n_cmp    = 0;
    int n_bad    = 0;
    int exp_done = 0;

    barret_arb_1213 dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation: accept, then watch the 3-cycle latency.
    task automatic single_op(input bit id, input logic [20:0] val, input logic [10:0] expo);
        if (id) begin
            req1_valid = 1'b1;
            req1_data  = val;
        end else begin
            req0_valid = 1'b1;
            req0_data  = val;
        end
        #1;
        chk("single_rdy_sel", id ? req1_ready : req0_ready, 1);
        chk("single_rdy_oth", id ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("single_lat1_valid", out_valid, 0);
        chk("single_busy", busy, 1);
        tick();
        #1;
        chk("single_lat2_valid", out_valid, 0);
        tick();
        #1;
        chk("single_lat3_valid", out_valid, 1);
        chk("single_data", out_data, expo);
        chk("single_id", out_id, id);
        exp_done++;
        tick();
        #1;
        chk("single_done_cnt", done_cnt, exp_done);
        chk("single_after_valid", out_valid, 0);
    endtask

    logic [20:0] bvals [4];
    logic [10:0] bexp  [4];
    logic [20:0] pvals [3];

    initial begin
        bvals = '{21'd0, 21'd1212, 21'd1213, 21'd2426};
        bexp  = '{11'd0, 11'd1212, 11'd0, 11'd0};
        pvals = '{21'd100, 21'd200, 21'd300};

        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 21'd5;
        req1_valid = 1'b0;
        req1_data  = '0;
        out_ready  = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_busy", busy, 0);
        rst        = 1'b0;
        req0_valid = 1'b0;
        tick();
        #1;
        chk("idle_busy", busy, 0);

        // ---------------- single op ----------------
        single_op(1'b0, 21'd5000, 11'd148);

        // ---------------- boundaries, back-to-back on req1 ----------------
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                req1_valid = 1'b1;
                req1_data  = bvals[i];
            end else begin
                req1_valid = 1'b0;
            end
            #1;
            if (i < 4) chk("bnd_ready1", req1_ready, 1);
            if (i >= 3) begin
                chk("bnd_valid", out_valid, 1);
                chk("bnd_data", out_data, bexp[i-3]);
                chk("bnd_id", out_id, 1);
                exp_done++;
            end
            tick();
        end
        #1;
        chk("bnd_drained", out_valid, 0);
        chk("bnd_done_cnt", done_cnt, exp_done);

        // ---------------- truncation corner ----------------
        single_op(1'b1, 21'd2097151, 11'd1276);

        // ---------------- contention ----------------
        // Last grant was requester 1, so requester 0 goes first.
        req0_data = 21'd5000;   // -> 148
        req1_data = 21'd1212;   // -> 1212
        for (int i = 0; i < 9; i++) begin
            req0_valid = (i < 6);
            req1_valid = (i < 6);
            #1;
            if (i < 6) begin
                chk("cont_ready0", req0_ready, (i % 2 == 0));
                chk("cont_ready1", req1_ready, (i % 2 == 1));
            end
            if (i >= 3) begin
                chk("cont_valid", out_valid, 1);
                chk("cont_id", out_id, ((i - 3) % 2));
                chk("cont_data", out_data, ((i - 3) % 2 == 1) ? 1212 : 148);
                exp_done++;
            end
            tick();
        end
        #1;
        chk("cont_drained", out_valid, 0);
        chk("cont_done_cnt", done_cnt, exp_done);

        // ---------------- backpressure ----------------
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_data  = pvals[i];
            #1;
            chk("bp_fill_ready0", req0_ready, 1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            out_ready  = 1'b0;
            req0_valid = 1'b1;
            req0_data  = 21'd400;
            req1_valid = 1'b1;
            req1_data  = 21'd900;
            #1;
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 100);
            chk("bp_id", out_id, 0);
            chk("bp_busy", busy, 1);
            chk("bp_done_cnt", done_cnt, exp_done);
            tick();
        end
        out_ready  = 1'b1;
        req1_valid = 1'b0;
        #1;
        chk("bp_rel_ready0", req0_ready, 1);
        chk("bp_rel_data", out_data, 100);
        exp_done++;
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_data", out_data, (i + 2) * 100);
            exp_done++;
            tick();
        end
        #1;
        chk("bp_end_valid", out_valid, 0);
        chk("bp_end_done_cnt", done_cnt, exp_done);
        chk("bp_end_busy", busy, 0);

        // ---------------- reset mid-flight ----------------
        // Last grant was requester 0, so the pointer now favours requester 1.
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_data  = pvals[i];
            #1;
            chk("rmf_fill_ready0", req0_ready, 1);
            tick();
        end
        rst        = 1'b1;
        req0_data  = 21'd500;
        #1;
        chk("rmf_rst_ready0", req0_ready, 0);
        chk("rmf_full_busy", busy, 1);
        tick();
        rst        = 1'b0;
        exp_done   = 0;
        req0_valid = 1'b1;
        req0_data  = 21'd700;
        req1_valid = 1'b1;
        req1_data  = 21'd800;
        #1;
        chk("rmf_busy", busy, 0);
        chk("rmf_out_valid", out_valid, 0);
        chk("rmf_out_data", out_data, 0);
        chk("rmf_done_cnt", done_cnt, 0);
        chk("rmf_ptr_ready0", req0_ready, 1);
        chk("rmf_ptr_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i == 2) begin
                chk("rmf_new_valid", out_valid, 1);
                chk("rmf_new_data", out_data, 700);
                chk("rmf_new_id", out_id, 0);
                exp_done++;
            end else begin
                chk("rmf_no_stale", out_valid, 0);
            end
            tick();
        end
        #1;
        chk("rmf_done_final", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
